// File: rtl/flip_result_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flip_result_scanner                                        |
// | Description : After an image flip, reads every word of a ROWS x COLS     |
// |               BRAM image once, sums the words into a checksum and        |
// |               (optionally) counts words that differ from the expected    |
// |               horizontally flipped ramp. Drives four status LEDs.        |
// |                                                                          |
// | Ports       : clk          - single clock, rising edge                   |
// |               reset        - asynchronous, active-high                   |
// |               start        - one-cycle scan request (honoured in IDLE)   |
// |               bram_en      - BRAM read enable                            |
// |               bram_addr    - BRAM read address                           |
// |               bram_dout    - BRAM read data, one cycle after the address |
// |               busy         - scan in progress                            |
// |               done         - one-cycle completion pulse                  |
// |               checksum     - sum of scanned words mod 2^DATA_W           |
// |               mismatch_cnt - saturating count of pattern mismatches      |
// |               leds         - [0] complete (sticky) [1] pass [2] fail     |
// |                              [3] busy                                    |
// |                                                                          |
// | Build macro : FLIP_PATTERN_CHECK_EN - enables the flipped-ramp compare;  |
// |               when undefined mismatch_cnt is tied to zero.               |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flip_result_scanner #(
  parameter int ROWS   = 4,
  parameter int COLS   = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [15:0]       mismatch_cnt,
  output logic [3:0]        leds
);

  localparam int                C_NUM_WORDS = ROWS * COLS;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(C_NUM_WORDS - 1);

  // The image must fit in the addressable BRAM space.
  if (C_NUM_WORDS > (2 ** ADDR_W)) begin : g_param_check
    $error("flip_result_scanner: ROWS*COLS exceeds 2**ADDR_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  // Read pipeline stage: marks that bram_dout carries the word for rd_addr_q.
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                sticky_q,   sticky_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      checksum_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      checksum_q <= checksum_d;
      sticky_q   <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    checksum_d = checksum_q;
    sticky_d   = sticky_q;
    bram_en    = 1'b0;
    done       = 1'b0;

    // Data for the address issued last cycle is on bram_dout now.
    if (rd_valid_q) begin
      checksum_d = checksum_q + bram_dout;
    end

    case (state_q)
      IDLE: begin
        // rd_valid_q is always low in IDLE, so clearing here loses nothing.
        if (start) begin
          state_d    = READ;
          addr_d     = '0;
          checksum_d = '0;
        end
      end
      READ: begin
        bram_en    = 1'b1;
        rd_valid_d = 1'b1;
        rd_addr_d  = addr_q;
        // Counter parks on the last address rather than wrapping.
        if (addr_q == C_LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // The final word is captured this cycle; move on once it is in.
        if (rd_valid_q && (rd_addr_q == C_LAST_ADDR)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        sticky_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FLIP_PATTERN_CHECK_EN
  logic [15:0]       mismatch_q, mismatch_d;
  logic [31:0]       rd_addr_ext;
  logic [31:0]       rd_col;
  logic [31:0]       flipped_val;
  logic [DATA_W-1:0] expected_word;

  // Word at r*COLS+c should hold r*COLS+(COLS-1-c) = addr + COLS-1 - 2c.
  assign rd_addr_ext   = 32'(rd_addr_q);
  assign rd_col        = rd_addr_ext % 32'(COLS);
  assign flipped_val   = rd_addr_ext - rd_col + (32'(COLS) - 32'd1 - rd_col);
  assign expected_word = DATA_W'(flipped_val);

  always_comb begin
    mismatch_d = mismatch_q;
    if ((state_q == IDLE) && start) begin
      mismatch_d = '0;
    end else if (rd_valid_q && (bram_dout != expected_word) &&
                 (mismatch_q != 16'hFFFF)) begin
      mismatch_d = mismatch_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_q <= '0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_cnt = mismatch_q;
`else
  assign mismatch_cnt = 16'd0;
`endif

  assign busy      = (state_q != IDLE);
  assign bram_addr = addr_q;
  assign checksum  = checksum_q;
  assign leds[0]   = sticky_q;
  assign leds[1]   = sticky_q & (mismatch_cnt == 16'd0) & ~busy;
  assign leds[2]   = sticky_q & (mismatch_cnt != 16'd0) & ~busy;
  assign leds[3]   = busy;

endmodule
`default_nettype wire
